hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, clock; reset in 1, async active-low reset; clock and reset listed first.
REQ-002 SHALL have ports: IDEX_MemRead in 1, load in EX; IDEX_rt in 5, load destination; IFID_rs in 5, ID source; IFID_rt in 5, ID source; ID_UsesRt in 1, ID reads rt.
REQ-003 SHALL have ports: Branch_EX in 1, branch taken in EX; Jump_ID in 1, jump/jr decoded in ID; Exc_ID in 1, undefined opcode in ID.
REQ-004 SHALL have ports: irq in 1, async external interrupt level; Kernel in 1, PC[31]; mem_busy in 1, data memory wait; cnt_clr in 1, clears stall counter.
REQ-005 SHALL have ports: PC_Write out 1; IFID_Write out 1; IFID_Flush out 1; IDEX_Flush out 1; Pipe_Hold out 1, freezes IF/ID, ID/EX, EX/MEM and MEM/WB.
REQ-006 SHALL have ports: PCSrc out 3, 0 PC+4, 1 branch, 2 jump, 3 ILLOP 0x80000004, 4 XADR 0x80000008; Save_EPC out 1; irq_ack out 1; stall_cnt out 16.

Function
REQ-007 SHALL implement FSM states RUN, IRQ_PEND and IRQ_ENTER, plus a 1-bit irq_taken latch.
REQ-008 SHALL synchronise irq through two flops to irq_s, with 2-cycle latency.
REQ-009 SHALL drive, while mem_busy=1 in any state: Pipe_Hold=1, PC_Write=0, IFID_Write=0, all flushes 0, PCSrc=0, Save_EPC=0, irq_ack=0, FSM frozen.
REQ-010 SHALL, when mem_busy=0 in RUN, apply the first matching condition in this order: Branch_EX, Exc_ID, irq request, load-use, Jump_ID, default.
REQ-011 SHALL, on Branch_EX: PCSrc=1, IFID_Flush=1, IDEX_Flush=1, for one cycle.
REQ-012 SHALL, on Exc_ID: PCSrc=3, IFID_Flush=1, IDEX_Flush=1, Save_EPC=1, for one cycle.
REQ-013 SHALL form the irq request as irq_s=1, Kernel=0 and irq_taken=0; on request SHALL go to IRQ_ENTER, or to IRQ_PEND if load-use or Jump_ID is active that cycle, with those actions performed normally.
REQ-014 SHALL define load-use as IDEX_MemRead=1, IDEX_rt!=0, and (IDEX_rt==IFID_rs or (ID_UsesRt=1 and IDEX_rt==IFID_rt)).
REQ-015 SHALL, on load-use: PC_Write=0, IFID_Write=0, IDEX_Flush=1, for exactly one cycle.
REQ-016 SHALL, on Jump_ID: PCSrc=2, IFID_Flush=1.
REQ-017 SHALL, by default: PC_Write=1, IFID_Write=1, PCSrc=0, all flushes 0.
REQ-018 SHALL, in IRQ_PEND, behave as RUN except the irq request is not re-evaluated; SHALL go to IRQ_ENTER when neither load-use nor Jump_ID is active.
REQ-019 SHALL, in IRQ_PEND, take Branch_EX or Exc_ID with priority and stay in IRQ_PEND.
REQ-020 SHALL, in IRQ_ENTER, assert for one cycle: PCSrc=4, IFID_Flush=1, IDEX_Flush=1, Save_EPC=1, irq_ack=1; SHALL set irq_taken and return to RUN.
REQ-021 SHALL, if Branch_EX=1 in IRQ_ENTER, serve the branch (REQ-011) and remain in IRQ_ENTER.
REQ-022 SHALL clear irq_taken when irq_s=0; one irq level yields exactly one irq_ack.
REQ-023 SHALL increment stall_cnt each cycle PC_Write=0 and reset=1, saturating at 0xFFFF; cnt_clr=1 SHALL force 0 next edge, with clear winning over increment.

Reset
REQ-024 SHALL, while reset=0, hold state=RUN, irq_taken=0, sync flops=0 and stall_cnt=0.
REQ-025 SHALL gate outputs while reset=0 to PC_Write=0, IFID_Write=0, flushes=0, Pipe_Hold=0, PCSrc=0, Save_EPC=0, irq_ack=0.
REQ-026 SHALL abandon IRQ_PEND or IRQ_ENTER without an ack when reset is asserted mid-sequence.

Structure
REQ-027 SHALL place PCSrc encodings, the FSM state encoding and the ILLOP/XADR constants in shared package cpu_pkg.
REQ-028 SHALL implement the synchroniser as sub-module irq_sync; all other logic SHALL be flat.

Verification
REQ-029 SHALL cover: IDEX_MemRead=1, IDEX_rt=8, IFID_rs=8 -> one cycle PC_Write=0, IDEX_Flush=1, stall_cnt=1; rt=0 -> no stall.
REQ-030 SHALL cover: Branch_EX=1 and Exc_ID=1 together -> PCSrc=1, Save_EPC=0.
REQ-031 SHALL cover: irq rises, Kernel=0 -> irq_ack exactly once, 3 cycles later (2 sync + 1 enter), PCSrc=4; irq held 20 cycles -> no second ack.
REQ-032 SHALL cover: irq request coincident with load-use -> IRQ_PEND, then IRQ_ENTER next cycle; with Kernel=1 -> no ack.
REQ-033 SHALL cover: mem_busy=1 for 5 cycles during IRQ_ENTER -> Pipe_Hold=1, no ack until mem_busy=0, stall_cnt +5.
REQ-034 SHALL cover: reset low in IRQ_PEND -> state RUN, stall_cnt=0, no irq_ack after release with irq=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source select codes, hazard FSM states and
// the exception vector addresses.
package cpu_pkg;

   typedef enum logic [2:0] {
      PCSRC_PC4    = 3'd0,
      PCSRC_BRANCH = 3'd1,
      PCSRC_JUMP   = 3'd2,
      PCSRC_ILLOP  = 3'd3,
      PCSRC_XADR   = 3'd4
   } pcsrc_t;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      IRQ_PEND  = 2'd1,
      IRQ_ENTER = 2'd2
   } hz_state_t;

   localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
   localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for the asynchronous external interrupt level.
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   output logic irq_s
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= irq;
         r_sync <= r_meta;
      end
   end

   assign irq_s = r_sync;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump/exception
// redirects, interrupt entry sequencing and a stall-cycle counter.
module hazard_ctrl
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        IDEX_MemRead,
   input  logic [4:0]  IDEX_rt,
   input  logic [4:0]  IFID_rs,
   input  logic [4:0]  IFID_rt,
   input  logic        ID_UsesRt,
   input  logic        Branch_EX,
   input  logic        Jump_ID,
   input  logic        Exc_ID,
   input  logic        irq,
   input  logic        Kernel,
   input  logic        mem_busy,
   input  logic        cnt_clr,
   output logic        PC_Write,
   output logic        IFID_Write,
   output logic        IFID_Flush,
   output logic        IDEX_Flush,
   output logic        Pipe_Hold,
   output logic [2:0]  PCSrc,
   output logic        Save_EPC,
   output logic        irq_ack,
   output logic [15:0] stall_cnt
);

   hz_state_t   r_state;
   hz_state_t   w_state_nxt;
   logic        r_taken;
   logic [15:0] r_cnt;
   logic        w_irq_s;
   logic        w_irq_req;
   logic        w_load_use;
   logic        w_set_taken;
   logic        w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush;
   logic        w_hold, w_save_epc, w_ack;
   pcsrc_t      w_pcsrc;

   irq_sync u_irq_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq),
      .irq_s (w_irq_s)
   );

   assign w_irq_req  = w_irq_s & ~Kernel & ~r_taken;
   assign w_load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                       ((IDEX_rt == IFID_rs) || (ID_UsesRt && (IDEX_rt == IFID_rt)));

   always_comb begin
      w_pc_write   = 1'b1;
      w_ifid_write = 1'b1;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_hold       = 1'b0;
      w_pcsrc      = PCSRC_PC4;
      w_save_epc   = 1'b0;
      w_ack        = 1'b0;
      w_set_taken  = 1'b0;
      w_state_nxt  = r_state;
      if (mem_busy) begin
         w_hold       = 1'b1;
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
      end else if (Branch_EX) begin
         // A resolved branch always wins; any pending interrupt entry waits.
         w_pcsrc      = PCSRC_BRANCH;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if (r_state == IRQ_ENTER) begin
         w_pcsrc      = PCSRC_XADR;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
         w_save_epc   = 1'b1;
         w_ack        = 1'b1;
         w_set_taken  = 1'b1;
         w_state_nxt  = RUN;
      end else if (Exc_ID) begin
         w_pcsrc      = PCSRC_ILLOP;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
         w_save_epc   = 1'b1;
      end else begin
         if (w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
         end else if (Jump_ID) begin
            w_pcsrc      = PCSRC_JUMP;
            w_ifid_flush = 1'b1;
         end
         // Entry is deferred while ID holds a stalled or redirecting instruction.
         if ((r_state == IRQ_PEND) || ((r_state == RUN) && w_irq_req))
            w_state_nxt = (w_load_use || Jump_ID) ? IRQ_PEND : IRQ_ENTER;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= RUN;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         r_taken <= 1'b0;
      else if (!w_irq_s)  r_taken <= 1'b0;
      else if (w_set_taken) r_taken <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            r_cnt <= 16'd0;
      else if (cnt_clr)                      r_cnt <= 16'd0;
      else if (!w_pc_write && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
   end

   assign PC_Write   = reset & w_pc_write;
   assign IFID_Write = reset & w_ifid_write;
   assign IFID_Flush = reset & w_ifid_flush;
   assign IDEX_Flush = reset & w_idex_flush;
   assign Pipe_Hold  = reset & w_hold;
   assign PCSrc      = reset ? w_pcsrc : PCSRC_PC4;
   assign Save_EPC   = reset & w_save_epc;
   assign irq_ack    = reset & w_ack;
   assign stall_cnt  = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, redirects, interrupt entry,
// memory wait, mid-sequence reset and counter saturation.
module tb_hazard_ctrl;

   logic        clk, reset;
   logic        IDEX_MemRead, ID_UsesRt, Branch_EX, Jump_ID, Exc_ID;
   logic        irq, Kernel, mem_busy, cnt_clr;
   logic [4:0]  IDEX_rt, IFID_rs, IFID_rt;
   logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold;
   logic [2:0]  PCSrc;
   logic        Save_EPC, irq_ack;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt), .IFID_rs(IFID_rs),
      .IFID_rt(IFID_rt), .ID_UsesRt(ID_UsesRt),
      .Branch_EX(Branch_EX), .Jump_ID(Jump_ID), .Exc_ID(Exc_ID),
      .irq(irq), .Kernel(Kernel), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
      .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .IDEX_Flush(IDEX_Flush), .Pipe_Hold(Pipe_Hold), .PCSrc(PCSrc),
      .Save_EPC(Save_EPC), .irq_ack(irq_ack), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ins();
      IDEX_MemRead = 0; IDEX_rt = 0; IFID_rs = 0; IFID_rt = 0; ID_UsesRt = 0;
      Branch_EX = 0; Jump_ID = 0; Exc_ID = 0; Kernel = 0; mem_busy = 0; cnt_clr = 0;
   endtask

   task automatic clr_cnt();
      cnt_clr = 1; step(); cnt_clr = 0;
   endtask

   task automatic test_reset();
      reset = 0; irq = 0; clear_ins();
      mem_busy = 1; Branch_EX = 1;
      #2;
      checks++;
      if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold} !== 5'b0) begin
         errors++; $display("FAIL reset_gate: got %b required 00000",
                            {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold});
      end
      checks++;
      if (PCSrc !== 3'd0 || Save_EPC !== 1'b0 || irq_ack !== 1'b0) begin
         errors++; $display("FAIL reset_pcsrc: got %0d/%b/%b required 0/0/0", PCSrc, Save_EPC, irq_ack);
      end
      step(); step();
      checks++;
      if (stall_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d required 0", stall_cnt);
      end
      clear_ins(); reset = 1;
      #1;
      checks++;
      if (PC_Write !== 1'b1 || IFID_Write !== 1'b1 || PCSrc !== 3'd0 || IDEX_Flush !== 1'b0) begin
         errors++; $display("FAIL default: got pcw=%b ifw=%b src=%0d idf=%b required 1 1 0 0",
                            PC_Write, IFID_Write, PCSrc, IDEX_Flush);
      end
      step();
   endtask

   task automatic test_load_use();
      clr_cnt();
      IDEX_MemRead = 1; IDEX_rt = 8; IFID_rs = 8;
      #1;
      checks++;
      if (PC_Write !== 0 || IFID_Write !== 0 || IDEX_Flush !== 1 || IFID_Flush !== 0) begin
         errors++; $display("FAIL loaduse_rs: got pcw=%b ifw=%b idf=%b iff=%b required 0 0 1 0",
                            PC_Write, IFID_Write, IDEX_Flush, IFID_Flush);
      end
      step();
      IDEX_MemRead = 0;
      #1;
      checks++;
      if (stall_cnt !== 16'd1 || PC_Write !== 1'b1) begin
         errors++; $display("FAIL loaduse_one_cycle: got cnt=%0d pcw=%b required 1 1", stall_cnt, PC_Write);
      end
      IDEX_MemRead = 1; IDEX_rt = 0; IFID_rs = 0;
      #1;
      checks++;
      if (PC_Write !== 1'b1 || IDEX_Flush !== 1'b0) begin
         errors++; $display("FAIL loaduse_rt0: got pcw=%b idf=%b required 1 0", PC_Write, IDEX_Flush);
      end
      IDEX_rt = 9; IFID_rs = 3; IFID_rt = 9; ID_UsesRt = 0;
      #1;
      checks++;
      if (PC_Write !== 1'b1) begin
         errors++; $display("FAIL loaduse_rt_unused: got pcw=%b required 1", PC_Write);
      end
      ID_UsesRt = 1;
      #1;
      checks++;
      if (PC_Write !== 1'b0 || IDEX_Flush !== 1'b1) begin
         errors++; $display("FAIL loaduse_rt_used: got pcw=%b idf=%b required 0 1", PC_Write, IDEX_Flush);
      end
      step();
      clear_ins();
      #1;
      checks++;
      if (stall_cnt !== 16'd2) begin
         errors++; $display("FAIL loaduse_cnt: got %0d required 2", stall_cnt);
      end
   endtask

   task automatic test_redirects();
      Branch_EX = 1; Exc_ID = 1;
      #1;
      checks++;
      if (PCSrc !== 3'd1 || Save_EPC !== 0 || IFID_Flush !== 1 || IDEX_Flush !== 1) begin
         errors++; $display("FAIL branch_over_exc: got src=%0d epc=%b iff=%b idf=%b required 1 0 1 1",
                            PCSrc, Save_EPC, IFID_Flush, IDEX_Flush);
      end
      Branch_EX = 0;
      #1;
      checks++;
      if (PCSrc !== 3'd3 || Save_EPC !== 1 || IFID_Flush !== 1 || IDEX_Flush !== 1) begin
         errors++; $display("FAIL exc: got src=%0d epc=%b iff=%b idf=%b required 3 1 1 1",
                            PCSrc, Save_EPC, IFID_Flush, IDEX_Flush);
      end
      Exc_ID = 0; Jump_ID = 1;
      #1;
      checks++;
      if (PCSrc !== 3'd2 || IFID_Flush !== 1 || IDEX_Flush !== 0 || PC_Write !== 1) begin
         errors++; $display("FAIL jump: got src=%0d iff=%b idf=%b pcw=%b required 2 1 0 1",
                            PCSrc, IFID_Flush, IDEX_Flush, PC_Write);
      end
      IDEX_MemRead = 1; IDEX_rt = 4; IFID_rs = 4;
      #1;
      checks++;
      if (PC_Write !== 0 || PCSrc !== 3'd0 || IFID_Flush !== 0) begin
         errors++; $display("FAIL loaduse_over_jump: got pcw=%b src=%0d iff=%b required 0 0 0",
                            PC_Write, PCSrc, IFID_Flush);
      end
      clear_ins();
      step();
   endtask

   task automatic test_irq_single();
      int acks;
      irq = 1;
      step();
      checks++;
      if (irq_ack !== 0) begin errors++; $display("FAIL irq_early1: got %b required 0", irq_ack); end
      step();
      checks++;
      if (irq_ack !== 0) begin errors++; $display("FAIL irq_early2: got %b required 0", irq_ack); end
      step();
      checks++;
      if (irq_ack !== 1 || PCSrc !== 3'd4 || Save_EPC !== 1 || IFID_Flush !== 1 || IDEX_Flush !== 1) begin
         errors++; $display("FAIL irq_enter: got ack=%b src=%0d epc=%b iff=%b idf=%b required 1 4 1 1 1",
                            irq_ack, PCSrc, Save_EPC, IFID_Flush, IDEX_Flush);
      end
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         acks += int'(irq_ack);
      end
      checks++;
      if (acks != 0) begin errors++; $display("FAIL irq_held_reack: got %0d acks required 0", acks); end
      irq = 0;
      repeat (4) step();
   endtask

   task automatic test_irq_loaduse();
      int acks;
      irq = 1;
      step(); step();
      IDEX_MemRead = 1; IDEX_rt = 8; IFID_rs = 8;
      #1;
      checks++;
      if (PC_Write !== 0 || irq_ack !== 0 || IDEX_Flush !== 1) begin
         errors++; $display("FAIL irq_lu_stall: got pcw=%b ack=%b idf=%b required 0 0 1", PC_Write, irq_ack, IDEX_Flush);
      end
      step();
      clear_ins();
      #1;
      checks++;
      if (irq_ack !== 0 || PC_Write !== 1) begin
         errors++; $display("FAIL irq_pend: got ack=%b pcw=%b required 0 1", irq_ack, PC_Write);
      end
      step();
      checks++;
      if (irq_ack !== 1 || PCSrc !== 3'd4) begin
         errors++; $display("FAIL irq_pend_enter: got ack=%b src=%0d required 1 4", irq_ack, PCSrc);
      end
      step();
      irq = 0;
      repeat (4) step();
      irq = 1; Kernel = 1;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         acks += int'(irq_ack);
      end
      checks++;
      if (acks != 0) begin errors++; $display("FAIL irq_kernel: got %0d acks required 0", acks); end
      irq = 0;
      repeat (4) step();
      Kernel = 0;
   endtask

   task automatic test_mem_busy();
      clr_cnt();
      irq = 1;
      step(); step(); step();
      mem_busy = 1;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (Pipe_Hold !== 1 || irq_ack !== 0 || PC_Write !== 0 || PCSrc !== 3'd0) begin
            errors++; $display("FAIL busy_hold[%0d]: got hold=%b ack=%b pcw=%b src=%0d required 1 0 0 0",
                               i, Pipe_Hold, irq_ack, PC_Write, PCSrc);
         end
         step();
      end
      mem_busy = 0;
      #1;
      checks++;
      if (irq_ack !== 1 || PCSrc !== 3'd4 || Pipe_Hold !== 0) begin
         errors++; $display("FAIL busy_release: got ack=%b src=%0d hold=%b required 1 4 0", irq_ack, PCSrc, Pipe_Hold);
      end
      checks++;
      if (stall_cnt !== 16'd5) begin
         errors++; $display("FAIL busy_cnt: got %0d required 5", stall_cnt);
      end
      step();
      checks++;
      if (irq_ack !== 0) begin errors++; $display("FAIL busy_single_ack: got %b required 0", irq_ack); end
      irq = 0;
      repeat (4) step();
   endtask

   task automatic test_reset_mid();
      int acks;
      irq = 1;
      step(); step();
      IDEX_MemRead = 1; IDEX_rt = 8; IFID_rs = 8;
      step();
      clear_ins(); irq = 0; reset = 0;
      #1;
      checks++;
      if (stall_cnt !== 16'd0 || irq_ack !== 0 || PC_Write !== 0) begin
         errors++; $display("FAIL rst_mid: got cnt=%0d ack=%b pcw=%b required 0 0 0", stall_cnt, irq_ack, PC_Write);
      end
      step(); step();
      reset = 1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         acks += int'(irq_ack);
         step();
      end
      checks++;
      if (acks != 0 || stall_cnt !== 16'd0 || PC_Write !== 1) begin
         errors++; $display("FAIL rst_mid_after: got acks=%0d cnt=%0d pcw=%b required 0 0 1", acks, stall_cnt, PC_Write);
      end
   endtask

   task automatic test_cnt_saturate();
      clr_cnt();
      mem_busy = 1;
      repeat (65535) step();
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL cnt_reach_max: got %0h required ffff", stall_cnt);
      end
      repeat (3) step();
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL cnt_saturate: got %0h required ffff", stall_cnt);
      end
      cnt_clr = 1;
      step();
      checks++;
      if (stall_cnt !== 16'd0) begin
         errors++; $display("FAIL cnt_clr_wins: got %0h required 0", stall_cnt);
      end
      clear_ins();
      step();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirects();
      test_irq_single();
      test_irq_loaduse();
      test_mem_busy();
      test_reset_mid();
      test_cnt_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
